// File: rtl/lp_divider_arbiter.sv
// Round-robin front end that shares one pipelined low-pass divider among CH_NUM channels.
// Issuing channels are tracked in a tag FIFO so each quotient is routed back to its owner.
module lp_divider_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int SUM_WIDTH   = 19,
  parameter int DATA_WIDTH  = 16,
  parameter int LP_DEPTH    = 8,
  parameter int DIV_LATENCY = 20,
  parameter int TAG_DEPTH   = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [CH_NUM-1:0]              req_vld_i,
  input  logic [CH_NUM*SUM_WIDTH-1:0]    req_sum_i,
  output logic [CH_NUM-1:0]              req_rdy_o,
  output logic                           div_tvalid_o,
  output logic [23:0]                    div_dividend_o,
  output logic [7:0]                     div_divisor_o,
  input  logic                           div_dout_tvalid_i,
  input  logic [31:0]                    div_dout_tdata_i,
  output logic [CH_NUM-1:0]              lp_vld_o,
  output logic [CH_NUM*DATA_WIDTH-1:0]   lp_data_o,
  output logic                           tag_err_o
);

  localparam int CH_W   = $clog2(CH_NUM);
  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int DRN_W  = $clog2(DIV_LATENCY + 2);
  localparam logic [DRN_W-1:0]  DRAIN_INIT = DRN_W'(DIV_LATENCY + 1);
  localparam logic [TAG_AW:0]   CNT_FULL   = (TAG_AW+1)'(TAG_DEPTH);
  localparam logic [CH_W:0]     CH_MOD     = (CH_W+1)'(CH_NUM);

  logic [CH_W-1:0]   r_ptr;
  logic [DRN_W-1:0]  r_drain;
  logic [CH_W-1:0]   r_tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] r_wr_ptr;
  logic [TAG_AW-1:0] r_rd_ptr;
  logic [TAG_AW:0]   r_count;

  logic                 w_found;
  logic [CH_W-1:0]      w_gnt_idx;
  logic [CH_W:0]        w_sum_idx;
  logic [CH_W-1:0]      w_idx;
  logic                 w_allow;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_err;
  logic                 w_drained;
  logic                 w_empty;
  logic                 w_full;
  logic [CH_W-1:0]      w_tag;
  logic [CH_W-1:0]      w_ptr_nxt;
  logic [SUM_WIDTH-1:0] w_gnt_sum;
  logic                 w_unused;

  assign div_divisor_o = 8'(LP_DEPTH);
  assign w_drained     = (r_drain == '0);
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CNT_FULL);
  assign w_tag         = r_tag_mem[r_rd_ptr];
  assign w_gnt_sum     = req_sum_i[w_gnt_idx*SUM_WIDTH +: SUM_WIDTH];
  assign w_ptr_nxt     = (w_gnt_idx == CH_W'(CH_NUM - 1)) ? '0 : w_gnt_idx + CH_W'(1);
  assign w_unused      = ^{div_dout_tdata_i[31:24], div_dout_tdata_i[7:0]};

  // First requester at or after the round-robin pointer wins.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum_idx = '0;
    w_idx     = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_sum_idx = {1'b0, r_ptr} + (CH_W+1)'(i);
      if (w_sum_idx >= CH_MOD) begin
        w_sum_idx = w_sum_idx - CH_MOD;
      end else begin
        w_sum_idx = w_sum_idx;
      end
      w_idx = w_sum_idx[CH_W-1:0];
      if (!w_found && req_vld_i[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx;
      end else begin
        w_found   = w_found;
      end
    end
  end

  // Fullness is judged before any same-cycle pop, so a full FIFO blocks the grant outright.
  always_comb begin
    w_allow = !rst_i && !w_full && w_drained;
    if (w_allow && w_found) begin
      req_rdy_o = CH_NUM'(1) << w_gnt_idx;
    end else begin
      req_rdy_o = '0;
    end
    w_push = w_allow && w_found;
    w_pop  = div_dout_tvalid_i && w_drained && !w_empty;
    w_err  = div_dout_tvalid_i && w_drained && w_empty;
  end

  // Tag storage holds the channel index of each issued dividend.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_gnt_idx;
    end
  end

  // Control state, issue path and result routing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr          <= '0;
      r_drain        <= DRAIN_INIT;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      div_tvalid_o   <= 1'b0;
      div_dividend_o <= 24'd0;
      lp_vld_o       <= '0;
      lp_data_o      <= '0;
      tag_err_o      <= 1'b0;
    end else begin
      if (!w_drained) begin
        r_drain <= r_drain - DRN_W'(1);
      end
      div_tvalid_o <= w_push;
      if (w_push) begin
        r_ptr          <= w_ptr_nxt;
        r_wr_ptr       <= r_wr_ptr + TAG_AW'(1);
        div_dividend_o <= 24'(w_gnt_sum);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + TAG_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (TAG_AW+1)'(1);
        2'b01:   r_count <= r_count - (TAG_AW+1)'(1);
        default: r_count <= r_count;
      endcase
      lp_vld_o <= '0;
      if (w_pop) begin
        lp_vld_o[w_tag]                             <= 1'b1;
        lp_data_o[w_tag*DATA_WIDTH +: DATA_WIDTH]   <= div_dout_tdata_i[8 +: DATA_WIDTH];
      end
      if (w_err) begin
        tag_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lp_divider_arbiter.sv
// Directed bench for lp_divider_arbiter: a latency-accurate divider model plus a
// scoreboard of expected per-channel results, checked with immediate assertions.
module tb_lp_divider_arbiter;

  localparam int CH = 4;
  localparam int SW = 19;
  localparam int DW = 16;
  localparam int LP = 8;
  localparam int DL = 20;
  localparam int TD = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [CH-1:0]     req_vld_i;
  logic [CH*SW-1:0]  req_sum_i;
  logic [CH-1:0]     req_rdy_o;
  logic              div_tvalid_o;
  logic [23:0]       div_dividend_o;
  logic [7:0]        div_divisor_o;
  logic              div_dout_tvalid_i;
  logic [31:0]       div_dout_tdata_i;
  logic [CH-1:0]     lp_vld_o;
  logic [CH*DW-1:0]  lp_data_o;
  logic              tag_err_o;

  always #5 clk = ~clk;

  lp_divider_arbiter #(
    .CH_NUM(CH), .SUM_WIDTH(SW), .DATA_WIDTH(DW),
    .LP_DEPTH(LP), .DIV_LATENCY(DL), .TAG_DEPTH(TD)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_vld_i(req_vld_i), .req_sum_i(req_sum_i), .req_rdy_o(req_rdy_o),
    .div_tvalid_o(div_tvalid_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_dout_tvalid_i(div_dout_tvalid_i), .div_dout_tdata_i(div_dout_tdata_i),
    .lp_vld_o(lp_vld_o), .lp_data_o(lp_data_o), .tag_err_o(tag_err_o)
  );

  typedef struct { int ch; logic [15:0] data; int t; } exp_t;
  typedef struct { int due; logic [31:0] data; } dres_t;

  exp_t         exp_q [$];
  logic [23:0]  iss_q [$];
  dres_t        div_q [$];
  logic [DW-1:0] shadow [CH];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_xfer = 0;
  int mark;
  logic [CH-1:0] obs_rdy;
  bit one_shot, stall, inject, lat_chk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*DW-1:0] shadow_flat();
    logic [CH*DW-1:0] v;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = shadow[k];
    return v;
  endfunction

  // One clock: observe at the falling edge, then drive stimulus and the divider model after the rising edge.
  task automatic tick();
    int          xch;
    exp_t        e;
    dres_t       r;
    logic [23:0] s;
    xch = -1;
    @(negedge clk);
    obs_rdy = req_rdy_o;
    if (div_tvalid_o || iss_q.size() != 0) begin
      chk("issue_vld", 64'(div_tvalid_o), 64'(iss_q.size() != 0));
      if (iss_q.size() != 0) begin
        s = iss_q.pop_front();
        chk("dividend", 64'(div_dividend_o), 64'(s));
        chk("divisor", 64'(div_divisor_o), 64'(LP));
      end
      if (div_tvalid_o) begin
        r.due  = cyc + DL;
        r.data = 32'(div_dividend_o / 24'(LP)) << 8;
        div_q.push_back(r);
      end
    end
    if (lp_vld_o != '0) begin
      if (exp_q.size() == 0) begin
        chk("lp_unexpected", 64'(lp_vld_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        shadow[e.ch] = e.data;
        chk("lp_ch", 64'(lp_vld_o), 64'd1 << e.ch);
        chk("lp_data", 64'(lp_data_o), 64'(shadow_flat()));
        if (lat_chk) chk("lp_latency", 64'(cyc - e.t), 64'(DL + 2));
      end
    end
    if (req_rdy_o != '0) chk("rdy_onehot", 64'($countones(req_rdy_o)), 64'd1);
    if ((req_vld_i & req_rdy_o) != '0) begin
      for (int k = CH - 1; k >= 0; k--) if (req_vld_i[k] && req_rdy_o[k]) xch = k;
      s      = 24'(req_sum_i[xch*SW +: SW]);
      e.ch   = xch;
      e.data = 16'(s / 24'(LP));
      e.t    = cyc;
      exp_q.push_back(e);
      iss_q.push_back(s);
      n_xfer++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (xch >= 0) begin
      req_sum_i[xch*SW +: SW] = SW'($urandom);
      if (one_shot) req_vld_i[xch] = 1'b0;
    end
    if (inject) begin
      div_dout_tvalid_i = 1'b1;
      div_dout_tdata_i  = 32'hABCD_EF00;
      inject = 1'b0;
    end else if (!stall && div_q.size() != 0 && div_q[0].due <= cyc) begin
      r = div_q.pop_front();
      div_dout_tvalid_i = 1'b1;
      div_dout_tdata_i  = r.data;
    end else begin
      div_dout_tvalid_i = 1'b0;
      div_dout_tdata_i  = 32'd0;
    end
  endtask

  initial begin
    rst_i = 1'b1;
    req_vld_i = '0;
    req_sum_i = '0;
    div_dout_tvalid_i = 1'b0;
    div_dout_tdata_i = 32'd0;
    one_shot = 1'b0;
    stall = 1'b0;
    inject = 1'b0;
    lat_chk = 1'b1;
    for (int k = 0; k < CH; k++) shadow[k] = '0;
    for (int k = 0; k < CH; k++) req_sum_i[k*SW +: SW] = SW'($urandom);

    // Reset state
    repeat (3) tick();
    req_vld_i = '1;
    #1;
    chk("rst_rdy", 64'(req_rdy_o), 64'd0);
    chk("rst_lp_vld", 64'(lp_vld_o), 64'd0);
    chk("rst_lp_data", 64'(lp_data_o), 64'd0);
    chk("rst_div_vld", 64'(div_tvalid_o), 64'd0);
    chk("rst_dividend", 64'(div_dividend_o), 64'd0);
    chk("rst_divisor", 64'(div_divisor_o), 64'(LP));
    chk("rst_tag_err", 64'(tag_err_o), 64'd0);

    // Drain window, then continuous round-robin from all channels
    rst_i = 1'b0;
    for (int i = 0; i < DL + 1; i++) begin
      tick();
      chk("drain_rdy", 64'(obs_rdy), 64'd0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_grant", 64'(obs_rdy), 64'd1 << (i % CH));
    end
    repeat (40) tick();
    req_vld_i = '0;
    repeat (30) tick();
    chk("rr_drained", 64'(exp_q.size()), 64'd0);

    // Single ch1 request of 800
    one_shot = 1'b1;
    mark = n_xfer;
    req_sum_i[1*SW +: SW] = 19'd800;
    req_vld_i = 4'b0010;
    repeat (30) tick();
    chk("t1_xfers", 64'(n_xfer - mark), 64'd1);
    chk("t1_ch1_data", 64'(lp_data_o[1*DW +: DW]), 64'd100);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // Extreme sums on ch3 and ch2
    req_sum_i[3*SW +: SW] = 19'h7FFFF;
    req_sum_i[2*SW +: SW] = 19'd0;
    req_vld_i = 4'b1100;
    repeat (30) tick();
    chk("t6_ch3_data", 64'(lp_data_o[3*DW +: DW]), 64'd65535);
    chk("t6_ch2_data", 64'(lp_data_o[2*DW +: DW]), 64'd0);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);

    // Tag FIFO full: withhold results until TD are outstanding
    one_shot = 1'b0;
    stall = 1'b1;
    lat_chk = 1'b0;
    mark = n_xfer;
    req_vld_i = 4'b0001;
    repeat (40) tick();
    chk("t3_outstanding", 64'(n_xfer - mark), 64'(TD));
    chk("t3_full_rdy", 64'(obs_rdy), 64'd0);
    stall = 1'b0;
    tick();
    tick();
    chk("t3_pop_cycle_rdy", 64'(obs_rdy), 64'd0);
    tick();
    chk("t3_resume_rdy", 64'(obs_rdy), 64'd1);
    req_vld_i = '0;
    repeat (60) tick();
    chk("t3_drained", 64'(exp_q.size()), 64'd0);
    chk("t3_tag_err", 64'(tag_err_o), 64'd0);
    lat_chk = 1'b1;

    // Reset with five requests in flight
    mark = n_xfer;
    req_vld_i = '1;
    repeat (5) tick();
    chk("t5_inflight", 64'(n_xfer - mark), 64'd5);
    rst_i = 1'b1;
    tick();
    exp_q.delete();
    iss_q.delete();
    for (int k = 0; k < CH; k++) shadow[k] = '0;
    rst_i = 1'b0;
    #1;
    chk("t5_lp_vld", 64'(lp_vld_o), 64'd0);
    chk("t5_lp_data", 64'(lp_data_o), 64'd0);
    chk("t5_div_vld", 64'(div_tvalid_o), 64'd0);
    chk("t5_dividend", 64'(div_dividend_o), 64'd0);
    for (int i = 0; i < DL + 1; i++) begin
      tick();
      chk("t5_drain_rdy", 64'(obs_rdy), 64'd0);
    end
    tick();
    chk("t5_resume_rdy", 64'(obs_rdy), 64'd1);
    req_vld_i = '0;
    repeat (30) tick();
    chk("t5_drained", 64'(exp_q.size()), 64'd0);
    chk("t5_model_empty", 64'(div_q.size()), 64'd0);
    chk("t5_tag_err", 64'(tag_err_o), 64'd0);

    // Result with no outstanding tag
    inject = 1'b1;
    tick();
    tick();
    chk("t4_err_set", 64'(tag_err_o), 64'd1);
    repeat (5) tick();
    chk("t4_err_sticky", 64'(tag_err_o), 64'd1);
    chk("t4_lp_vld", 64'(lp_vld_o), 64'd0);
    chk("t4_lp_data", 64'(lp_data_o), 64'(shadow_flat()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
